// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver
// Channel arbiter for a 4-channel 8237A-style DMA controller. Merges the
// hardware DREQ pins with the software request and mask registers, handles
// the HRQ/HLDA handshake with the bus master, and grants one channel with
// DACK until the timing-control block reports end of service.

module dma_priority_resolver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] dreq,
    input  logic [7:0] command_reg,
    input  logic [3:0] request_reg,
    input  logic [3:0] mask_reg,
    input  logic       hlda,
    input  logic       svc_done,
    output logic       hrq,
    output logic [3:0] dack,
    output logic       grant_valid,
    output logic [1:0] grant_ch,
    output logic [3:0] pending
);

    // A synchronizer chain needs at least one flop, whatever the parameter says
    localparam int STAGES = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_GRANT   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [3:0] sync_q [STAGES];
    logic [3:0] dreq_s;
    logic [3:0] eff_req;
    logic [1:0] state;
    logic [1:0] top;
    logic [1:0] base;
    logic [1:0] cand;
    logic [1:0] winner;
    logic       found;
    logic [3:0] dack_hi;
    logic       ctrl_disable;
    logic       rotate_mode;
    logic       unused_cmd_bits;

    assign ctrl_disable    = command_reg[2];
    assign rotate_mode     = command_reg[4];
    assign unused_cmd_bits = ^{command_reg[5], command_reg[3], command_reg[1:0]};

    // Bring the asynchronous DREQ pins into the clock domain
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= 4'b0000;
            end
        end else begin
            sync_q[0] <= dreq;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign dreq_s  = sync_q[STAGES-1] ^ {4{command_reg[6]}};
    assign eff_req = (dreq_s & ~mask_reg) | request_reg;

    // Register the effective request vector; it drives both the FSM and status
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pending <= 4'b0000;
        end else begin
            pending <= eff_req;
        end
    end

    // Pick the first pending channel, scanning from channel 0 or from top
    always_comb begin
        base   = rotate_mode ? top : 2'd0;
        cand   = 2'd0;
        winner = 2'd0;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = base + 2'(k);
            if (!found && pending[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Hold handshake, grant latching and rotation pointer update
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            hrq         <= 1'b0;
            grant_valid <= 1'b0;
            grant_ch    <= 2'd0;
            top         <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!ctrl_disable && (pending != 4'b0000)) begin
                        hrq   <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if ((pending == 4'b0000) || ctrl_disable) begin
                        hrq   <= 1'b0;
                        state <= ST_IDLE;
                    end else if (hlda) begin
                        grant_ch    <= winner;
                        grant_valid <= 1'b1;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (svc_done) begin
                        grant_valid <= 1'b0;
                        hrq         <= 1'b0;
                        top         <= grant_ch + 2'd1;
                        state       <= hlda ? ST_RELEASE : ST_IDLE;
                    end else if (!hlda) begin
                        grant_valid <= 1'b0;
                        hrq         <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    hrq <= 1'b0;
                    if (!hlda) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    hrq         <= 1'b0;
                    grant_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // DACK follows the grant combinationally so it is correct even in reset
    always_comb begin
        dack_hi = grant_valid ? (4'b0001 << grant_ch) : 4'b0000;
        dack    = command_reg[7] ? dack_hi : ~dack_hi;
    end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// tb_dma_priority_resolver
// Directed and randomized bench for the DMA priority resolver, with a
// queue-based priority-order reference model.

module tb_dma_priority_resolver;

   localparam int SYNC = 2;

   logic       CLK;
   logic       RESET;
   logic [3:0] dreq;
   logic [7:0] command_reg;
   logic [3:0] request_reg;
   logic [3:0] mask_reg;
   logic       hlda;
   logic       svc_done;
   logic       hrq;
   logic [3:0] dack;
   logic       grant_valid;
   logic [1:0] grant_ch;
   logic [3:0] pending;

   int compared   = 0;
   int mismatched = 0;
   int order[$];

   dma_priority_resolver #(.SYNC_STAGES(SYNC)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .dreq(dreq),
      .command_reg(command_reg),
      .request_reg(request_reg),
      .mask_reg(mask_reg),
      .hlda(hlda),
      .svc_done(svc_done),
      .hrq(hrq),
      .dack(dack),
      .grant_valid(grant_valid),
      .grant_ch(grant_ch),
      .pending(pending)
   );

   // Free-running 100 MHz clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] d, input logic [7:0] cmd, input logic [3:0] req, input logic [3:0] msk);
      dreq        = d;
      command_reg = cmd;
      request_reg = req;
      mask_reg    = msk;
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   function automatic logic [3:0] modelEff();
      logic [3:0] lvl;
      lvl = command_reg[6] ? ~dreq : dreq;
      return (lvl & ~mask_reg) | request_reg;
   endfunction

   function automatic int modelWinner(input logic [3:0] eff, input logic rot);
      if (!rot) begin
         for (int c = 0; c < 4; c++) if (eff[c]) return c;
      end else begin
         for (int i = 0; i < 4; i++) if (eff[order[i]]) return order[i];
      end
      return -1;
   endfunction

   function automatic logic [3:0] modelDack(input logic gv, input int g);
      logic [3:0] oh;
      oh = gv ? (4'b0001 << g) : 4'b0000;
      return command_reg[7] ? oh : ~oh;
   endfunction

   // After servicing g, the channel after g becomes the highest priority
   task automatic modelService(input int g);
      while (order[0] != ((g + 1) % 4)) order.push_back(order.pop_front());
   endtask

   task automatic modelReset();
      order = '{0, 1, 2, 3};
   endtask

   task automatic doReset(input logic [7:0] cmd);
      applyStimulus(4'b0000, cmd, 4'b0000, 4'b0000);
      hlda     = 1'b0;
      svc_done = 1'b0;
      RESET    = 1'b0;
      step(2);
      checkOutput("rst_hrq", hrq, 1'b0);
      checkOutput("rst_gv", grant_valid, 1'b0);
      checkOutput("rst_pending", pending, 4'b0000);
      checkOutput("rst_dack", dack, modelDack(1'b0, 0));
      RESET = 1'b1;
      modelReset();
      step(1);
   endtask

   task automatic waitHrq(input string tag, input int budget);
      for (int i = 0; i < budget && hrq !== 1'b1; i++) step(1);
      checkOutput({tag, "_hrq"}, hrq, 1'b1);
   endtask

   // Let inputs settle, complete the hold handshake and check the grant
   task automatic grantRound(input string tag, output int g);
      step(SYNC + 3);
      g = modelWinner(modelEff(), command_reg[4]);
      waitHrq(tag, 20);
      hlda = 1'b1;
      step(1);
      checkOutput({tag, "_gv"}, grant_valid, 1'b1);
      checkOutput({tag, "_gch"}, grant_ch, g);
      checkOutput({tag, "_dack"}, dack, modelDack(1'b1, g));
   endtask

   task automatic finishSvc(input string tag, input int g);
      svc_done = 1'b1;
      step(1);
      svc_done = 1'b0;
      modelService(g);
      checkOutput({tag, "_svc_gv"}, grant_valid, 1'b0);
      checkOutput({tag, "_svc_hrq"}, hrq, 1'b0);
      checkOutput({tag, "_svc_dack"}, dack, modelDack(1'b0, 0));
      step(1);
      checkOutput({tag, "_rel_hrq"}, hrq, 1'b0);
      hlda = 1'b0;
      step(1);
   endtask

   task automatic abortGrant(input string tag);
      hlda = 1'b0;
      step(1);
      checkOutput({tag, "_abt_hrq"}, hrq, 1'b0);
      checkOutput({tag, "_abt_gv"}, grant_valid, 1'b0);
      checkOutput({tag, "_abt_dack"}, dack, modelDack(1'b0, 0));
   endtask

   // svc_done together with hlda falling goes straight back to IDLE
   task automatic simultEnd(input string tag, input int g);
      svc_done = 1'b1;
      hlda     = 1'b0;
      step(1);
      svc_done = 1'b0;
      modelService(g);
      checkOutput({tag, "_sim_gv"}, grant_valid, 1'b0);
      checkOutput({tag, "_sim_hrq"}, hrq, 1'b0);
      if (modelEff() != 4'b0000 && !command_reg[2]) begin
         step(1);
         checkOutput({tag, "_sim_rereq"}, hrq, 1'b1);
      end
   endtask

   // Directed scenarios followed by randomized rounds
   initial begin
      int g;
      int g2;
      logic [3:0] e;
      logic [7:0] cmd;
      logic [3:0] req;
      int kind;

      // Reset state
      doReset(8'h00);

      // Fixed priority with pipeline latency
      applyStimulus(4'b1010, 8'h00, 4'b0000, 4'b0000);
      step(SYNC);
      checkOutput("lat_pending_early", pending, 4'b0000);
      step(1);
      checkOutput("lat_pending", pending, 4'b1010);
      checkOutput("lat_hrq_early", hrq, 1'b0);
      step(1);
      checkOutput("lat_hrq", hrq, 1'b1);
      hlda = 1'b1;
      step(1);
      checkOutput("fix1_gch", grant_ch, 2'd1);
      checkOutput("fix1_dack", dack, 4'b1101);
      dreq = 4'b1000;
      finishSvc("fix1", 1);
      grantRound("fix2", g);
      checkOutput("fix2_ch3", grant_ch, 2'd3);
      finishSvc("fix2", g);

      // Rotating priority, all channels requesting
      doReset(8'h10);
      applyStimulus(4'b1111, 8'h10, 4'b0000, 4'b0000);
      for (int r = 0; r < 5; r++) begin
         grantRound("rot", g);
         checkOutput("rot_seq", grant_ch, r % 4);
         finishSvc("rot", g);
      end

      // Mask versus software request, plus ignored hlda/svc_done in IDLE
      applyStimulus(4'b1111, 8'h00, 4'b0000, 4'b1111);
      step(SYNC + 4);
      checkOutput("mask_pending", pending, 4'b0000);
      checkOutput("mask_hrq", hrq, 1'b0);
      hlda = 1'b1;
      svc_done = 1'b1;
      step(3);
      svc_done = 1'b0;
      checkOutput("idle_hlda_hrq", hrq, 1'b0);
      checkOutput("idle_hlda_gv", grant_valid, 1'b0);
      hlda = 1'b0;
      step(1);
      request_reg = 4'b0100;
      grantRound("swreq", g);
      checkOutput("swreq_ch2", grant_ch, 2'd2);
      finishSvc("swreq", g);
      request_reg = 4'b0000;

      // Polarity bits
      applyStimulus(4'b1110, 8'hC0, 4'b0000, 4'b0000);
      grantRound("pol", g);
      checkOutput("pol_ch0", grant_ch, 2'd0);
      checkOutput("pol_dack", dack, 4'b0001);
      finishSvc("pol", g);

      // Abort keeps the rotation pointer
      applyStimulus(4'b1111, 8'h10, 4'b0000, 4'b0000);
      grantRound("abt", g);
      abortGrant("abt");
      grantRound("abt2", g2);
      checkOutput("abt_same_top", g2, g);

      // Disabling during GRANT does not abort the service
      command_reg = 8'h14;
      step(3);
      checkOutput("dis_grant_gv", grant_valid, 1'b1);
      checkOutput("dis_grant_hrq", hrq, 1'b1);
      finishSvc("dis", g2);
      step(3);
      checkOutput("dis_idle_hrq", hrq, 1'b0);

      // Disabling during REQ drops hrq on the next edge
      command_reg = 8'h10;
      waitHrq("disreq", 20);
      command_reg = 8'h14;
      step(1);
      checkOutput("disreq_hrq", hrq, 1'b0);
      command_reg = 8'h10;

      // Simultaneous svc_done and hlda drop
      grantRound("sim", g);
      simultEnd("sim", g);
      grantRound("sim2", g);
      finishSvc("sim2", g);

      // Async reset in the middle of a grant
      grantRound("arst", g);
      #2;
      RESET = 1'b0;
      #1;
      checkOutput("arst_hrq", hrq, 1'b0);
      checkOutput("arst_gv", grant_valid, 1'b0);
      checkOutput("arst_dack", dack, modelDack(1'b0, 0));
      hlda = 1'b0;
      step(1);
      RESET = 1'b1;
      modelReset();
      step(1);

      // Randomized rounds against the reference model
      for (int r = 0; r < 40; r++) begin
         cmd = 8'h00;
         cmd[4] = 1'($urandom_range(0, 1));
         cmd[6] = 1'($urandom_range(0, 1));
         cmd[7] = 1'($urandom_range(0, 1));
         req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         applyStimulus(4'($urandom), cmd, req, 4'($urandom));
         hlda = 1'b0;
         step(SYNC + 4);
         e = modelEff();
         checkOutput("rnd_pending", pending, e);
         if (e == 4'b0000) begin
            checkOutput("rnd_nohrq", hrq, 1'b0);
            checkOutput("rnd_dack_idle", dack, modelDack(1'b0, 0));
         end else begin
            grantRound("rnd", g);
            kind = $urandom_range(0, 2);
            if (kind == 0) finishSvc("rnd", g);
            else if (kind == 1) abortGrant("rnd");
            else simultEnd("rnd", g);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
